// File: rtl/keccak_sponge_ctrl_if.sv
// Sponge controller bus: message in, squeeze out, permutation core link.
// Signal names keep the controller's port naming; slave is the controller.
interface keccak_sponge_ctrl_if;
  logic          i_start;
  logic [63:0]   i_msg_data;
  logic          i_msg_valid;
  logic          i_msg_last;
  logic [3:0]    i_msg_nbytes;
  logic          o_msg_ready;
  logic [63:0]   o_sq_data;
  logic          o_sq_valid;
  logic          i_sq_ready;
  logic          i_sq_stop;
  logic [1599:0] o_perm_state;
  logic          o_perm_valid;
  logic          i_perm_ready;
  logic [1599:0] i_perm_state;
  logic          i_perm_valid;
  logic          o_busy;

  modport slave (
    input  i_start, i_msg_data, i_msg_valid,
    input  i_msg_last, i_msg_nbytes,
    input  i_sq_ready, i_sq_stop,
    input  i_perm_ready, i_perm_state, i_perm_valid,
    output o_msg_ready, o_sq_data, o_sq_valid,
    output o_perm_state, o_perm_valid, o_busy
  );

  modport master (
    output i_start, i_msg_data, i_msg_valid,
    output i_msg_last, i_msg_nbytes,
    output i_sq_ready, i_sq_stop,
    output i_perm_ready, i_perm_state, i_perm_valid,
    input  o_msg_ready, o_sq_data, o_sq_valid,
    input  o_perm_state, o_perm_valid, o_busy
  );
endinterface

// File: rtl/keccak_sponge_ctrl.sv
// Keccak sponge initiator: absorb 64-bit words, pad, drive the
// keccak-f[1600] core, squeeze rate words to the consumer.
module keccak_sponge_ctrl #(
  parameter int         RATE_WORDS = 17,
  parameter logic [7:0] DS_BYTE    = 8'h06
) (
  input logic                 i_clk,
  input logic                 i_rstn,
  keccak_sponge_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    PADBLK,
    P_REQ,
    P_WAIT,
    SQUEEZE
  } state_e;

  localparam int         RATE_BYTES = 8 * RATE_WORDS;
  localparam logic [4:0] LAST_W     = 5'(RATE_WORDS - 1);

  state_e        fsm_q;
  state_e        ret_q;
  logic [1599:0] st_q;
  logic [4:0]    widx_q;
  logic          msg_ready_q;
  logic          sq_valid_q;
  logic          perm_valid_q;
  logic          busy_q;

  logic [3:0]    nb;
  logic [63:0]   msg_mask;
  logic          no_room;
  logic [7:0]    ds_pos;
  logic          perm_done;
  logic [1599:0] absorb_d;
  logic [1599:0] pad_d;
  logic [63:0]   sq_word;

  assign nb = (bus.i_msg_nbytes > 4'd8) ?
              4'd8 : bus.i_msg_nbytes;

  // Leading nb bytes survive; a shift by 64 yields an all-ones mask.
  assign msg_mask = bus.i_msg_last ?
                    ~({64{1'b1}} >> {nb, 3'b000}) :
                    {64{1'b1}};

  assign no_room = bus.i_msg_last && (nb == 4'd8) &&
                   (widx_q == LAST_W);

  assign ds_pos = (fsm_q == PADBLK) ? 8'd0 :
                  ({widx_q, 3'b000} + {4'b0000, nb});

  assign perm_done = bus.i_perm_valid &&
                     ((fsm_q == P_WAIT) ||
                      ((fsm_q == P_REQ) && bus.i_perm_ready));

  always_comb begin
    absorb_d = st_q;
    sq_word  = '0;
    for (int w = 0; w < RATE_WORDS; w++) begin
      if (widx_q == 5'(w)) begin
        absorb_d[1599-64*w -: 64] = st_q[1599-64*w -: 64] ^
                                    (bus.i_msg_data & msg_mask);
        sq_word = st_q[1599-64*w -: 64];
      end
    end
  end

  // DS and the final 0x80 may land on the same byte; XOR merges them.
  always_comb begin
    pad_d = '0;
    for (int n = 0; n < RATE_BYTES; n++) begin
      if (ds_pos == 8'(n)) begin
        pad_d[1599-8*n -: 8] = DS_BYTE;
      end
    end
    pad_d[1599-8*(RATE_BYTES-1) -: 8] =
      pad_d[1599-8*(RATE_BYTES-1) -: 8] ^ 8'h80;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fsm_q        <= IDLE;
      ret_q        <= IDLE;
      st_q         <= '0;
      widx_q       <= '0;
      msg_ready_q  <= 1'b0;
      sq_valid_q   <= 1'b0;
      perm_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (bus.i_start) begin
            st_q        <= '0;
            widx_q      <= '0;
            msg_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            fsm_q       <= ABSORB;
          end
        end
        ABSORB: begin
          if (bus.i_msg_valid) begin
            if (bus.i_msg_last) begin
              st_q         <= no_room ? absorb_d :
                                        (absorb_d ^ pad_d);
              ret_q        <= no_room ? PADBLK : SQUEEZE;
              widx_q       <= '0;
              msg_ready_q  <= 1'b0;
              perm_valid_q <= 1'b1;
              fsm_q        <= P_REQ;
            end else begin
              st_q <= absorb_d;
              if (widx_q == LAST_W) begin
                ret_q        <= ABSORB;
                widx_q       <= '0;
                msg_ready_q  <= 1'b0;
                perm_valid_q <= 1'b1;
                fsm_q        <= P_REQ;
              end else begin
                widx_q <= widx_q + 5'd1;
              end
            end
          end
        end
        PADBLK: begin
          st_q         <= st_q ^ pad_d;
          ret_q        <= SQUEEZE;
          perm_valid_q <= 1'b1;
          fsm_q        <= P_REQ;
        end
        P_REQ, P_WAIT: begin
          if ((fsm_q == P_REQ) && bus.i_perm_ready) begin
            perm_valid_q <= 1'b0;
            fsm_q        <= P_WAIT;
          end
          if (perm_done) begin
            st_q        <= bus.i_perm_state;
            widx_q      <= '0;
            fsm_q       <= ret_q;
            msg_ready_q <= (ret_q == ABSORB);
            sq_valid_q  <= (ret_q == SQUEEZE);
          end
        end
        SQUEEZE: begin
          if (bus.i_sq_stop) begin
            sq_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            fsm_q      <= IDLE;
          end else if (bus.i_sq_ready) begin
            if (widx_q == LAST_W) begin
              widx_q       <= '0;
              sq_valid_q   <= 1'b0;
              perm_valid_q <= 1'b1;
              ret_q        <= SQUEEZE;
              fsm_q        <= P_REQ;
            end else begin
              widx_q <= widx_q + 5'd1;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.o_msg_ready  = msg_ready_q;
  assign bus.o_sq_data    = sq_word;
  assign bus.o_sq_valid   = sq_valid_q;
  assign bus.o_perm_state = st_q;
  assign bus.o_perm_valid = perm_valid_q;
  assign bus.o_busy       = busy_q;

endmodule
